fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the program counter.
- Samples the current PC and issues a single-outstanding request to instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Drives pc_stall so the PC only advances when a fetch is granted. Handles redirect flushes, including discarding an in-flight response.

---
 rtl/fetch_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: samples PC, keeps one instruction-memory request outstanding and buffers returned words for decode.
// Define FETCH_MISALIGN_CHECK_EN to turn misaligned PCs into fault entries (adds instr_misaligned).
module fetch_unit #(
    parameter int          DEPTH       = 2,
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        instr_misaligned
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_INC = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t         state_r;
    logic           outstanding_r;
    logic           req_r;
    logic [31:0]    addr_r;
    logic [31:0]    instr_mem_r [DEPTH];
    logic [31:0]    pc_mem_r    [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_next_s;
    logic           empty_s;
    logic           pop_s;
    logic           push_s;
    logic           rx_push_s;
    logic           fault_s;
    logic           issue_ok_s;
    logic           space_s;
    logic [31:0]    push_instr_s;
    logic [31:0]    push_pc_s;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic           mis_mem_r [DEPTH];
    logic           mis_pending_r;
`endif

    // Buffer bookkeeping and issue qualification
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        pop_s     = !empty_s && instr_ready && !flush;
        space_s   = (count_r + {{(CW-1){1'b0}}, outstanding_r}) < DEPTH_C;
        rx_push_s = (state_r == S_WAIT) && imem_rvalid && !flush;
`ifdef FETCH_MISALIGN_CHECK_EN
        issue_ok_s = (PC[1:0] == 2'b00) && !mis_pending_r;
        fault_s    = (state_r == S_IDLE) && !flush && space_s && !mis_pending_r && (PC[1:0] != 2'b00);
`else
        issue_ok_s = 1'b1;
        fault_s    = 1'b0;
`endif
        push_s = rx_push_s || fault_s;
        if (fault_s) begin
            push_instr_s = RESET_INSTR;
            push_pc_s    = PC;
        end else begin
            push_instr_s = imem_rdata;
            push_pc_s    = addr_r;
        end
        // flush wins over any same-cycle push or pop
        if (flush) begin
            count_next_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - ONE_C;
        end else begin
            count_next_s = count_r;
        end
    end

    // Request FSM with registered request outputs
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r       <= S_IDLE;
            outstanding_r <= 1'b0;
            req_r         <= 1'b0;
            addr_r        <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!flush && space_s && issue_ok_s) begin
                        state_r <= S_REQ;
                        req_r   <= 1'b1;
                        addr_r  <= PC;
                    end else begin
                        state_r <= S_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        req_r         <= 1'b0;
                        outstanding_r <= 1'b1;
                        state_r       <= flush ? S_DISCARD : S_WAIT;
                    end else if (flush) begin
                        req_r   <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        req_r   <= 1'b1;
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        outstanding_r <= 1'b0;
                        if (!flush && (count_next_s < DEPTH_C) && issue_ok_s) begin
                            state_r <= S_REQ;
                            req_r   <= 1'b1;
                            addr_r  <= PC;
                        end else begin
                            state_r <= S_IDLE;
                            req_r   <= 1'b0;
                        end
                    end else if (flush) begin
                        state_r <= S_DISCARD;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        outstanding_r <= 1'b0;
                        state_r       <= S_IDLE;
                    end else begin
                        state_r <= S_DISCARD;
                    end
                end
                default: begin
                    state_r       <= S_IDLE;
                    req_r         <= 1'b0;
                    outstanding_r <= 1'b0;
                end
            endcase
        end
    end

    // Instruction buffer storage and pointers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= RESET_INSTR;
                pc_mem_r[i]    <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
                mis_mem_r[i]   <= 1'b0;
`endif
            end
        end else begin
            count_r <= count_next_s;
            if (flush) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    instr_mem_r[wr_ptr_r] <= push_instr_s;
                    pc_mem_r[wr_ptr_r]    <= push_pc_s;
`ifdef FETCH_MISALIGN_CHECK_EN
                    mis_mem_r[wr_ptr_r]   <= fault_s;
`endif
                    wr_ptr_r <= wr_ptr_r + PTR_INC;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_INC;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // A fault entry blocks further issue until decode consumes it or a flush removes it
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mis_pending_r <= 1'b0;
        end else if (flush) begin
            mis_pending_r <= 1'b0;
        end else if (fault_s) begin
            mis_pending_r <= 1'b1;
        end else if (pop_s && mis_mem_r[rd_ptr_r]) begin
            mis_pending_r <= 1'b0;
        end else begin
            mis_pending_r <= mis_pending_r;
        end
    end
`endif

    // Head-of-buffer presentation to decode
    always_comb begin
        instr_valid = !empty_s;
        if (empty_s) begin
            instr    = RESET_INSTR;
            instr_pc = 32'h0000_0000;
        end else begin
            instr    = instr_mem_r[rd_ptr_r];
            instr_pc = pc_mem_r[rd_ptr_r];
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        if (empty_s) begin
            instr_misaligned = 1'b0;
        end else begin
            instr_misaligned = mis_mem_r[rd_ptr_r];
        end
`endif
    end

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign pc_stall  = !(req_r && imem_gnt);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level memory/PC model predicts decode traffic.
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        Clock       = 1'b0;
    logic        nReset      = 1'b0;
    logic [31:0] PC          = 32'h0;
    logic        flush       = 1'b0;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        instr_ready = 1'b0;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        instr_misaligned;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_INSTR(NOP)) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .PC          (PC),
        .flush       (flush),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .instr_misaligned (instr_misaligned)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          p_gnt, p_ready, p_flush, max_delay;
    bit          spurious_en, late_rvalid;
    logic [31:0] pc_m;
    bit          txn_busy, txn_killed;
    logic [31:0] txn_addr;
    int          txn_wait;
    bit          prev_flush = 1'b0;
    ent_t        mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[17:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One bus cycle: drive inputs after the edge, update the model at the falling edge
    task automatic step();
        bit   resp, busy0, granted;
        ent_t e;
        @(posedge Clock);
        #1;
        PC          = pc_m;
        flush       = (int'($urandom_range(99)) < p_flush);
        imem_gnt    = (int'($urandom_range(99)) < p_gnt);
        instr_ready = (int'($urandom_range(99)) < p_ready);
        resp = 1'b0;
        if (txn_busy && txn_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(txn_addr);
            resp        = 1'b1;
        end else begin
            if (txn_busy) txn_wait--;
            if (!txn_busy && (late_rvalid || (spurious_en && $urandom_range(99) < 5))) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEADBEEF;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end
        late_rvalid = 1'b0;
        @(negedge Clock);
        busy0   = txn_busy;
        granted = imem_req && imem_gnt;
        chk("pc_stall", 32'(pc_stall), 32'(!granted));
        if (busy0) chk("req_while_outstanding", 32'(imem_req), 32'h0);
        if (flush) txn_killed = 1'b1;
        if (resp) begin
            if (!txn_killed) begin
                e.pc   = txn_addr;
                e.data = mem_word(txn_addr);
                exp_q.push_back(e);
            end
            txn_busy = 1'b0;
        end
        if (granted) begin
            chk("imem_addr", imem_addr, pc_m);
            txn_busy   = 1'b1;
            txn_addr   = pc_m;
            txn_killed = flush;
            txn_wait   = int'($urandom_range(32'(max_delay)));
        end
        if (flush) pc_m = $urandom & 32'h000F_FFFC;
        else if (granted) pc_m = pc_m + 32'h4;
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #3;
        nReset = 1'b0;
        #1;
        chk("rst_async_req", 32'(imem_req), 32'h0);
        chk("rst_async_addr", imem_addr, 32'h0);
        chk("rst_async_instr", instr, NOP);
        chk("rst_async_instr_pc", instr_pc, 32'h0);
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        exp_q.delete();
        txn_busy   = 1'b0;
        txn_killed = 1'b0;
        pc_m       = 32'h0;
        PC         = 32'h0;
        repeat (3) @(posedge Clock);
        #1;
        nReset      = 1'b1;
        late_rvalid = 1'b1;
    endtask

    // Monitor: compares every decode handshake against the scoreboard
    always @(negedge Clock) begin
        if (!nReset) begin
            chk("rst_instr_valid", 32'(instr_valid), 32'h0);
            chk("rst_imem_req", 32'(imem_req), 32'h0);
            chk("rst_pc_stall", 32'(pc_stall), 32'h1);
            prev_flush = 1'b0;
        end else begin
            if (prev_flush) chk("valid_after_flush", 32'(instr_valid), 32'h0);
            if (!instr_valid) begin
                chk("empty_instr", instr, NOP);
                chk("empty_instr_pc", instr_pc, 32'h0);
            end else if (instr_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got pc %h instr %h, expected no entry", instr_pc, instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("instr", instr, mon_e.data);
                    chk("instr_pc", instr_pc, mon_e.pc);
                end
            end
            if (flush) exp_q.delete();
            prev_flush = flush;
        end
    end

    initial begin
        p_gnt = 100; p_ready = 100; p_flush = 0; max_delay = 0;
        spurious_en = 1'b0; late_rvalid = 1'b0;
        pc_m = 32'h0; txn_busy = 1'b0; txn_killed = 1'b0; txn_wait = 0; txn_addr = 32'h0;
        do_reset();
        repeat (12) step();

        // Decode stalled: buffer fills to DEPTH and issue stops
        p_ready = 0;
        repeat (20) step();
        chk("bp_imem_req", 32'(imem_req), 32'h0);
        chk("bp_pc_stall", 32'(pc_stall), 32'h1);
        chk("bp_instr_valid", 32'(instr_valid), 32'h1);
        chk("bp_entries", 32'(exp_q.size()), 32'(DEPTH));
        p_ready = 100;
        repeat (20) step();

        p_gnt = 60; p_ready = 70; p_flush = 8; max_delay = 2; spurious_en = 1'b1;
        repeat (3000) step();

        for (int i = 0; i < 50 && !txn_busy; i++) step();
        do_reset();
        repeat (1500) step();

        p_flush = 0; p_gnt = 0; p_ready = 100; spurious_en = 1'b0;
        repeat (10) step();
        chk("drain_entries", 32'(exp_q.size()), 32'h0);
        chk("drain_instr_valid", 32'(instr_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
